// File: rtl/uart_rx_frame_if.sv
// Serial receive link: line input plus the byte/strobe outputs toward the command parser.
interface uart_rx_frame_if;
  logic       RX;
  logic [7:0] RX_data;
  logic       RX_valid;
  logic       frame_err;
  logic       q_busy;

  modport master (output RX, input RX_data, RX_valid, frame_err, q_busy);
  modport slave  (input RX, output RX_data, RX_valid, frame_err, q_busy);
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling, one-clk valid/error strobes, good bytes only.
module uart_rx_frame #(
  parameter int BAUDRATE = 5000000,
  parameter int CLK_FREQ = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_frame_if.slave  rx_if
);
  localparam int CYCLES = CLK_FREQ / BAUDRATE;
  localparam int HALF   = CYCLES / 2;
  localparam int CW     = $clog2(CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync    <= 2'b11;
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync    <= {sync[0], rx_if.RX};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  // Every transition clears the clock counter so each phase times from its own entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, shreg[7:1]};
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a zero-gap next start edge be caught.
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_if.RX_data   = data_q;
  assign rx_if.RX_valid  = valid_q;
  assign rx_if.frame_err = err_q;
  assign rx_if.q_busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 10 clk/bit (clock period 10 time units).
module tb_uart_rx_frame;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  uart_rx_frame_if u_if();
  uart_rx_frame #(.BAUDRATE(5000000), .CLK_FREQ(50000000)) dut (
    .clk(clk), .reset(reset), .rx_if(u_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count strobes, log bytes, note overlap of valid and error.
  int         n_valid = 0;
  int         n_err = 0;
  int         overlap = 0;
  int         last_valid_cyc = 0;
  logic [7:0] rx_log[$];
  always @(negedge clk) begin
    if (u_if.RX_valid) begin
      n_valid++;
      rx_log.push_back(u_if.RX_data);
      last_valid_cyc = cyc;
    end
    if (u_if.frame_err) n_err++;
    if (u_if.RX_valid && u_if.frame_err) overlap++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
    u_if.RX = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      u_if.RX = b[i];
      #(bit_t);
    end
    u_if.RX = stop;
    #(bit_t);
    u_if.RX = 1'b1;
  endtask

  task automatic test_reset;
    u_if.RX = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (u_if.RX_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", u_if.RX_data); end
    total++; if (u_if.RX_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", u_if.RX_valid); end
    total++; if (u_if.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", u_if.frame_err); end
    total++; if (u_if.q_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", u_if.q_busy); end
    reset = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single;
    int v0, e0, t0;
    v0 = n_valid; e0 = n_err;
    @(posedge clk); #1;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 100);
    repeat (20) @(posedge clk);
    #1;
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", n_valid - v0); end
    total++; if (u_if.RX_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", u_if.RX_data); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL single_err got=%0d exp=0", n_err - e0); end
    total++; if (u_if.q_busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", u_if.q_busy); end
    total++;
    if (last_valid_cyc - t0 < 97 || last_valid_cyc - t0 > 99) begin
      bad++; $display("FAIL single_latency got=%0d exp=98+/-1", last_valid_cyc - t0);
    end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    @(posedge clk); #1;
    send_frame(8'h00, 1'b1, 100);
    send_frame(8'hFF, 1'b1, 100);
    repeat (20) @(posedge clk);
    #1;
    total++; if (n_valid - v0 !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n_valid - v0); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", n_err - e0); end
    if (rx_log.size() >= v0 + 2) begin
      total++; if (rx_log[v0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", rx_log[v0]); end
      total++; if (rx_log[v0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", rx_log[v0+1]); end
    end else begin
      total++; bad++; $display("FAIL b2b_log got=%0d exp=%0d", rx_log.size(), v0 + 2);
    end
  endtask

  task automatic test_glitch;
    int v0, e0, busy_cnt;
    v0 = n_valid; e0 = n_err; busy_cnt = 0;
    @(posedge clk); #1;
    u_if.RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    u_if.RX = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.q_busy) busy_cnt++;
    end
    total++; if (busy_cnt < 1 || busy_cnt > 8) begin bad++; $display("FAIL glitch_busy got=%0d exp=1..8", busy_cnt); end
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", n_valid - v0); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d exp=0", n_err - e0); end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    @(posedge clk); #1;
    send_frame(8'h11, 1'b1, 100);
    send_frame(8'h3C, 1'b0, 100);
    repeat (30) @(posedge clk);
    #1;
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL ferr_valid got=%0d exp=1", n_valid - v0); end
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", n_err - e0); end
    total++; if (u_if.RX_data !== 8'h11) begin bad++; $display("FAIL ferr_data got=%h exp=11", u_if.RX_data); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    int v0, e0;
    b = 8'h77;
    @(posedge clk); #1;
    u_if.RX = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      u_if.RX = b[i];
      #100;
    end
    u_if.RX = b[4];
    #50;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    total++; if (u_if.RX_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", u_if.RX_data); end
    total++; if (u_if.RX_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", u_if.RX_valid); end
    total++; if (u_if.frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", u_if.frame_err); end
    total++; if (u_if.q_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", u_if.q_busy); end
    u_if.RX = 1'b1;
    v0 = n_valid; e0 = n_err;
    repeat (30) @(posedge clk);
    #1;
    total++; if (n_valid - v0 + n_err - e0 !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d exp=0", n_valid - v0 + n_err - e0); end
    send_frame(8'h5A, 1'b1, 100);
    repeat (20) @(posedge clk);
    #1;
    total++; if (u_if.RX_data !== 8'h5A) begin bad++; $display("FAIL rstmid_next got=%h exp=5a", u_if.RX_data); end
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", n_valid - v0); end
  endtask

  task automatic test_skew;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    @(posedge clk); #1;
    send_frame(8'hC3, 1'b1, 104);
    repeat (30) @(posedge clk);
    #1;
    total++; if (u_if.RX_data !== 8'hC3) begin bad++; $display("FAIL skew_slow got=%h exp=c3", u_if.RX_data); end
    send_frame(8'h3C, 1'b1, 100);
    repeat (20) @(posedge clk);
    @(posedge clk); #1;
    send_frame(8'hC3, 1'b1, 96);
    repeat (30) @(posedge clk);
    #1;
    total++; if (u_if.RX_data !== 8'hC3) begin bad++; $display("FAIL skew_fast got=%h exp=c3", u_if.RX_data); end
    total++; if (n_valid - v0 !== 3) begin bad++; $display("FAIL skew_count got=%0d exp=3", n_valid - v0); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL skew_err got=%0d exp=0", n_err - e0); end
  endtask

  task automatic test_exclusive;
    total++; if (overlap !== 0) begin bad++; $display("FAIL exclusive got=%0d exp=0", overlap); end
  endtask

  initial begin
    u_if.RX = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_skew();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
